// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller and the pipeline
// registers it steers.
package pipe_ctrl_pkg;

    localparam int unsigned STATE_W    = 2;
    localparam int unsigned SEQ_CNT_W  = 4;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [STATE_W-1:0] RUN     = 2'd0;
    localparam logic [STATE_W-1:0] MD_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] FLUSH   = 2'd2;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Field order is the bit order the pipeline registers expect.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_bubble;
    } hz_ctrl_t;

    localparam int unsigned HZ_CTRL_W = $bits(hz_ctrl_t);

    localparam hz_ctrl_t CTRL_NORMAL = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
        idex_write: 1'b1, idex_bubble: 1'b0, exmem_bubble: 1'b0
    };

    // Redirect fetch and squash the wrong-path instructions in IF/ID and ID/EX.
    localparam hz_ctrl_t CTRL_SQUASH = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
        idex_write: 1'b1, idex_bubble: 1'b1, exmem_bubble: 1'b0
    };

    // Freeze the front end while EX is busy; EX/MEM sees bubbles meanwhile.
    localparam hz_ctrl_t CTRL_MD_HOLD = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
        idex_write: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b1
    };

    localparam hz_ctrl_t CTRL_LOAD_USE = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
        idex_write: 1'b1, idex_bubble: 1'b1, exmem_bubble: 1'b0
    };

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: ID/EX operand info in, pipeline-register controls and
// event counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import pipe_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] rs1_id;
    logic [REG_ADDR_W-1:0] rs2_id;
    logic                  use_rs1_id;
    logic                  use_rs2_id;
    logic [REG_ADDR_W-1:0] rd_ex;
    logic                  MemRead_ex;
    logic                  muldiv_ex;
    logic                  mispredict_ex;

    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_write;
    logic                  idex_bubble;
    logic                  exmem_bubble;
    logic [STATE_W-1:0]    ctrl_state;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex,
        output MemRead_ex, muldiv_ex, mispredict_ex,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
        input  ctrl_state, stall_count, flush_count
    );

    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex,
        input  MemRead_ex, muldiv_ex, mispredict_ex,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
        output ctrl_state, stall_count, flush_count
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: load-use stalls, mispredict squash with multi-cycle
// redirect and MUL/DIV occupancy of EX, plus saturating stall/flush event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_LAT   = 4,
    parameter int unsigned REDIRECT_LAT = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    if ((MULDIV_LAT < 2) || (MULDIV_LAT > 15)) begin : g_bad_muldiv_lat
        $error("pipeline_hazard_ctrl: MULDIV_LAT must be within 2..15");
    end
    if ((REDIRECT_LAT < 1) || (REDIRECT_LAT > 7)) begin : g_bad_redirect_lat
        $error("pipeline_hazard_ctrl: REDIRECT_LAT must be within 1..7");
    end

    // The entry cycle already counts as one, and cnt==0 marks the final cycle.
    localparam logic [SEQ_CNT_W-1:0] MD_CNT_INIT = SEQ_CNT_W'(MULDIV_LAT - 2);
    localparam logic [SEQ_CNT_W-1:0] REDIR_CNT_INIT =
        (REDIRECT_LAT > 1) ? SEQ_CNT_W'(REDIRECT_LAT - 2) : '0;

    logic [STATE_W-1:0]   state_q, state_d;
    logic [SEQ_CNT_W-1:0] cnt_q, cnt_d;
    hz_ctrl_t             ctrl;
    hz_ctrl_t             ctrl_out;
    logic                 stall_inc;
    logic                 flush_inc;
    logic                 rs1_hit;
    logic                 rs2_hit;
    logic                 load_use;

    assign rs1_hit  = bus.use_rs1_id && (bus.rs1_id == bus.rd_ex);
    assign rs2_hit  = bus.use_rs2_id && (bus.rs2_id == bus.rd_ex);
    assign load_use = bus.MemRead_ex && (bus.rd_ex != REG_ZERO) && (rs1_hit || rs2_hit);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl      = CTRL_NORMAL;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.mispredict_ex) begin
                    ctrl      = CTRL_SQUASH;
                    flush_inc = 1'b1;
                    if (REDIRECT_LAT > 1) begin
                        state_d = FLUSH;
                        cnt_d   = REDIR_CNT_INIT;
                    end
                end else if (bus.muldiv_ex) begin
                    ctrl      = CTRL_MD_HOLD;
                    stall_inc = 1'b1;
                    state_d   = MD_WAIT;
                    cnt_d     = MD_CNT_INIT;
                end else if (load_use) begin
                    ctrl      = CTRL_LOAD_USE;
                    stall_inc = 1'b1;
                end
            end
            MD_WAIT: begin
                // EX holds the MUL/DIV, so branch and load hazards cannot originate here.
                if (cnt_q != '0) begin
                    ctrl      = CTRL_MD_HOLD;
                    stall_inc = 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                ctrl = CTRL_SQUASH;
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Controls are forced low for as long as reset is held, independent of inputs.
    assign ctrl_out = hz_ctrl_t'(ctrl & {HZ_CTRL_W{reset}});

    assign bus.pc_write     = ctrl_out.pc_write;
    assign bus.ifid_write   = ctrl_out.ifid_write;
    assign bus.ifid_flush   = ctrl_out.ifid_flush;
    assign bus.idex_write   = ctrl_out.idex_write;
    assign bus.idex_bubble  = ctrl_out.idex_bubble;
    assign bus.exmem_bubble = ctrl_out.exmem_bubble;
    assign bus.ctrl_state   = state_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .inc_i   (stall_inc),
        .count_o (bus.stall_count)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .inc_i   (flush_inc),
        .count_o (bus.flush_count)
    );

    state_legal_a: assert property (@(posedge clk) disable iff (!reset)
        state_q != 2'd3);

endmodule
